// File: rtl/pwm_duty_capture_if.sv
// PWM capture bundle: waveform under test in, measurements out.
interface pwm_duty_capture_if #(
  parameter int CNT_W = 16
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [6:0]       duty_pct;
  logic             meas_valid;
  logic             overrun;
  logic             no_signal;
  logic             stuck_level;

  modport master (
    output pwm_in,
    input  high_cnt,
    input  period_cnt,
    input  duty_pct,
    input  meas_valid,
    input  overrun,
    input  no_signal,
    input  stuck_level
  );

  modport slave (
    input  pwm_in,
    output high_cnt,
    output period_cnt,
    output duty_pct,
    output meas_valid,
    output overrun,
    output no_signal,
    output stuck_level
  );
endinterface

// File: rtl/pwm_duty_capture.sv
// PWM high-time/period/duty capture with timeout detection.
// Optional PWM_CAP_GLITCH_FILTER_EN: 3-sample glitch filter on synced input.
module pwm_duty_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input logic               clk,
  input logic               rst,
  pwm_duty_capture_if.slave bus
);
  localparam int DW = CNT_W + 7;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  function automatic logic [CNT_W-1:0] inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic s1, s2, s, s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.pwm_in;
      s2 <= s1;
    end
  end

`ifdef PWM_CAP_GLITCH_FILTER_EN
  logic h0, h1, f_q;

  // level follows s2 only once three consecutive samples agree
  assign s = (s2 == h0 && h0 == h1) ? s2 : f_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h0  <= 1'b0;
      h1  <= 1'b0;
      f_q <= 1'b0;
    end else begin
      h0  <= s2;
      h1  <= h0;
      f_q <= s;
    end
  end
`else
  assign s = s2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_d <= 1'b0;
    else     s_d <= s;
  end

  logic rise, fall, toggle;
  assign rise   = s & ~s_d;
  assign fall   = ~s & s_d;
  assign toggle = rise | fall;

  // idle holds cycles elapsed since the last edge
  logic [CNT_W-1:0] idle;
  logic             tmo;
  assign tmo = !toggle &&
               (idle == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         idle <= '0;
    else if (toggle) idle <= CNT_W'(1);
    else             idle <= inc(idle);
  end

  state_t           state;
  logic [CNT_W-1:0] hcnt, pcnt;
  logic [DW-1:0]    rem, dvs, dividend;
  logic [6:0]       quo;
  logic [2:0]       step;
  logic             busy, qbit;

  // hcnt*100 as 64+32+4 shifted copies
  assign dividend = {1'b0, hcnt, 6'b0} +
                    {2'b0, hcnt, 5'b0} +
                    {5'b0, hcnt, 2'b0};
  assign qbit = (rem >= dvs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      hcnt            <= '0;
      pcnt            <= '0;
      rem             <= '0;
      dvs             <= '0;
      quo             <= '0;
      step            <= '0;
      busy            <= 1'b0;
      bus.high_cnt    <= '0;
      bus.period_cnt  <= '0;
      bus.duty_pct    <= '0;
      bus.meas_valid  <= 1'b0;
      bus.overrun     <= 1'b0;
      bus.no_signal   <= 1'b0;
      bus.stuck_level <= 1'b0;
    end else begin
      bus.meas_valid <= 1'b0;
      if (busy) begin
        if (qbit) rem <= rem - dvs;
        dvs  <= dvs >> 1;
        quo  <= {quo[5:0], qbit};
        step <= step - 1'b1;
        if (step == 3'd1) begin
          busy           <= 1'b0;
          bus.duty_pct   <= {quo[5:0], qbit};
          bus.meas_valid <= 1'b1;
        end
      end
      if (tmo) begin
        state           <= IDLE;
        busy            <= 1'b0;
        bus.meas_valid  <= 1'b0;
        bus.no_signal   <= 1'b1;
        bus.stuck_level <= s;
        bus.duty_pct    <= s ? 7'd100 : 7'd0;
        bus.high_cnt    <= '0;
        bus.period_cnt  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (rise) begin
              state           <= HIGH;
              hcnt            <= CNT_W'(1);
              pcnt            <= CNT_W'(1);
              bus.no_signal   <= 1'b0;
              bus.stuck_level <= 1'b0;
            end
          end
          HIGH: begin
            pcnt <= inc(pcnt);
            if (fall) state <= LOW;
            else      hcnt  <= inc(hcnt);
          end
          LOW: begin
            if (rise) begin
              if (busy) begin
                bus.overrun <= 1'b1;
              end else begin
                bus.high_cnt   <= hcnt;
                bus.period_cnt <= pcnt;
                rem            <= dividend;
                dvs            <= {1'b0, pcnt, 6'b0};
                quo            <= '0;
                step           <= 3'd7;
                busy           <= 1'b1;
              end
              hcnt  <= CNT_W'(1);
              pcnt  <= CNT_W'(1);
              state <= HIGH;
            end else begin
              pcnt <= inc(pcnt);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
